param_updown_counter: RTL and testbench

Parametrised, fully synchronous successor to the 4-bit asynchronous up counter. Adds configurable width and modulus, up/down direction, count enable and parallel load. Also adds a wrap or saturate boundary mode, a terminal-count pulse and a sticky overflow flag. Intended as the general-purpose counter for timers, dividers and event tallies across the design.

---
 rtl/counter_pkg.sv | 15 +
 rtl/sticky_flag.sv | 20 ++
 rtl/param_updown_counter.sv | 75 +++++++
 tb/tb_param_updown_counter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
// Direction/mode encodings plus the load-value clamp.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int unsigned clamp_max(input int unsigned val, input int unsigned max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/sticky_flag.sv
// Single-bit sticky status register: set wins over clear.
// Latency 1 cycle; no backpressure, async active-low reset.
module sticky_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= 1'b0;
    else if (set)
      q <= 1'b1;
    else if (clr)
      q <= 1'b0;
  end

endmodule

// File: rtl/param_updown_counter.sv
// Modulo MAX_VAL+1 up/down counter with load, wrap/saturate, tc pulse and sticky ovf.
// Latency 1 cycle input to outputs; no backpressure, en gates each step.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int          SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam bit               WRAP  = (SATURATE == MODE_WRAP);

  logic [WIDTH-1:0] count_d;
  logic             bnd;

  // Boundary is detected on the current count before stepping, so count never exceeds MAX_VAL.
  always_comb begin
    count_d = count;
    bnd     = 1'b0;
    if (load) begin
      count_d = WIDTH'(clamp_max(32'(load_val), MAX_VAL));
    end else if (en) begin
      case (up)
        CNT_UP: begin
          if (count == MAX_W) begin
            bnd     = 1'b1;
            count_d = WRAP ? '0 : MAX_W;
          end else begin
            count_d = count + 1'b1;
          end
        end
        CNT_DOWN: begin
          if (count == '0) begin
            bnd     = 1'b1;
            count_d = WRAP ? MAX_W : '0;
          end else begin
            count_d = count - 1'b1;
          end
        end
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= bnd;
    end
  end

  sticky_flag u_ovf (
    .clk (clk),
    .rst (rst),
    .set (bnd),
    .clr (clr_flag),
    .q   (ovf)
  );

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: a wrapping MAX_VAL=9 counter and a saturating MAX_VAL=15 counter share stimulus.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load, clr_flag;
  logic [3:0] load_val;
  logic [3:0] a_count, b_count;
  logic       a_tc, a_ovf, b_tc, b_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_flag(clr_flag), .count(a_count), .tc(a_tc), .ovf(a_ovf)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_flag(clr_flag), .count(b_count), .tc(b_tc), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_flag = 1'b0;

    // Reset state
    #10;
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_a_tc",    32'(a_tc),    0);
    chk("rst_a_ovf",   32'(a_ovf),   0);
    chk("rst_b_count", 32'(b_count), 0);

    // Wrap up: 1..9,0,1,2 with tc on the 9->0 edge
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("wrap_up_count", 32'(a_count), 32'(k % 10));
      chk("wrap_up_tc",    32'(a_tc),    (k == 10) ? 32'd1 : 32'd0);
      chk("wrap_up_ovf",   32'(a_ovf),   (k >= 10) ? 32'd1 : 32'd0);
    end
    chk("sat_up_count12", 32'(b_count), 12);

    // Wrap down from a load of 2
    load = 1'b1; load_val = 4'd2; up = 1'b0;
    tick();
    chk("load2_count", 32'(a_count), 2);
    chk("load2_tc",    32'(a_tc),    0);
    chk("load2_ovf",   32'(a_ovf),   1);
    load = 1'b0;
    tick(); chk("down_1", 32'(a_count), 1); chk("down_1_tc", 32'(a_tc), 0);
    tick(); chk("down_0", 32'(a_count), 0); chk("down_0_tc", 32'(a_tc), 0);
    tick(); chk("down_9", 32'(a_count), 9); chk("down_9_tc", 32'(a_tc), 1);
    chk("sat_down_pin", 32'(b_count), 0);  chk("sat_down_pin_tc", 32'(b_tc), 1);
    tick(); chk("down_8", 32'(a_count), 8); chk("down_8_tc", 32'(a_tc), 0);
    chk("sat_ovf_set", 32'(b_ovf), 1);

    // Load priority over en, clamp above MAX_VAL
    load = 1'b1; load_val = 4'd13; up = 1'b1;
    tick();
    chk("clamp_count", 32'(a_count), 9);
    chk("clamp_tc",    32'(a_tc),    0);
    chk("sat_load13",  32'(b_count), 13);

    // Flag race: clear in the same cycle as the 9->0 wrap keeps ovf
    load = 1'b0; clr_flag = 1'b1;
    tick();
    chk("race_count", 32'(a_count), 0);
    chk("race_tc",    32'(a_tc),    1);
    chk("race_ovf",   32'(a_ovf),   1);
    chk("sat_clr_ovf", 32'(b_ovf),  0);
    en = 1'b0;
    tick();
    chk("clr_ovf",    32'(a_ovf),   0);
    chk("hold_count", 32'(a_count), 0);
    chk("hold_tc",    32'(a_tc),    0);
    clr_flag = 1'b0;

    // Saturate up from 14
    load = 1'b1; load_val = 4'd14;
    tick(); chk("sat_load14", 32'(b_count), 14);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick(); chk("sat_15",   32'(b_count), 15); chk("sat_15_tc",   32'(b_tc), 0);
    tick(); chk("sat_pin1", 32'(b_count), 15); chk("sat_pin1_tc", 32'(b_tc), 1);
    tick(); chk("sat_pin2", 32'(b_count), 15); chk("sat_pin2_tc", 32'(b_tc), 1);
    chk("sat_up_ovf", 32'(b_ovf), 1);

    // Saturate down from 1
    load = 1'b1; load_val = 4'd1;
    tick(); chk("sat_load1", 32'(b_count), 1); chk("sat_load1_tc", 32'(b_tc), 0);
    load = 1'b0; up = 1'b0;
    tick(); chk("sat_dn0",  32'(b_count), 0); chk("sat_dn0_tc",  32'(b_tc), 0);
    tick(); chk("sat_dnpin", 32'(b_count), 0); chk("sat_dnpin_tc", 32'(b_tc), 1);
    chk("wrap_after_sat", 32'(a_count), 9);
    chk("wrap_ovf_again", 32'(a_ovf),   1);

    // Async reset mid-count
    load = 1'b1; load_val = 4'd6; en = 1'b0;
    tick();
    chk("pre_rst_count", 32'(a_count), 6);
    chk("pre_rst_ovf",   32'(a_ovf),   1);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 32'(a_count), 0);
    chk("arst_ovf",   32'(a_ovf),   0);
    chk("arst_tc",    32'(a_tc),    0);
    tick();
    chk("arst_hold_count", 32'(a_count), 0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(a_count), 1);
    chk("post_rst_tc",    32'(a_tc),    0);
    chk("post_rst_ovf",   32'(a_ovf),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
